// File: rtl/rs_issue_bank_pkg.sv
// Shared constants for the reservation-station bank: station types, op codes,
// the tag-0 "no producer" convention and the per-entry state encoding.
package rs_issue_bank_pkg;

   localparam int TAG_W  = 5;
   localparam int DATA_W = 32;
   localparam int OP_W   = 4;
   localparam int TYPE_W = 3;
   localparam int AGE_W  = 3;

   localparam logic [TYPE_W-1:0] ST_ADD = 3'd1;
   localparam logic [TYPE_W-1:0] ST_MUL = 3'd2;
   localparam logic [TYPE_W-1:0] ST_LD  = 3'd3;
   localparam logic [TYPE_W-1:0] ST_ST  = 3'd4;

   localparam logic [OP_W-1:0] OP_ADD = 4'd0;
   localparam logic [OP_W-1:0] OP_SUB = 4'd1;
   localparam logic [OP_W-1:0] OP_AND = 4'd2;
   localparam logic [OP_W-1:0] OP_OR  = 4'd3;

   localparam logic [TAG_W-1:0] TAG_NONE = 5'd0;

   typedef enum logic [1:0] {
      ENT_FREE,
      ENT_WAIT,
      ENT_READY,
      ENT_EXEC
   } ent_state_t;

   function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] immd, input logic zext);
      return zext ? {16'h0000, immd} : {{16{immd[15]}}, immd};
   endfunction

endpackage

// File: rtl/rs_issue_bank_if.sv
// Issue, CDB and functional-unit signals of one reservation-station bank.
// master = control unit / CDB / FU side, slave = the bank.
interface rs_issue_bank_if;
   import rs_issue_bank_pkg::*;

   logic              issuable;
   logic [TAG_W-1:0]  stnum_free;
   logic              issue_en;
   logic [TYPE_W-1:0] issue_type;
   logic [TAG_W-1:0]  issue_stnum;
   logic [OP_W-1:0]   issue_op;
   logic [DATA_W-1:0] issue_vj;
   logic [TAG_W-1:0]  issue_qj;
   logic [DATA_W-1:0] issue_vk;
   logic [TAG_W-1:0]  issue_qk;
   logic              issue_use_imm;
   logic [15:0]       issue_immd;
   logic              issue_imm_zext;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic              fu_ready;
   logic              fu_valid;
   logic [OP_W-1:0]   fu_op;
   logic [DATA_W-1:0] fu_a;
   logic [DATA_W-1:0] fu_b;
   logic [TAG_W-1:0]  fu_tag;

   modport master (
      input  issuable, stnum_free, fu_valid, fu_op, fu_a, fu_b, fu_tag,
      output issue_en, issue_type, issue_stnum, issue_op, issue_vj, issue_qj,
             issue_vk, issue_qk, issue_use_imm, issue_immd, issue_imm_zext,
             cdb_valid, cdb_tag, cdb_data, fu_ready
   );

   modport slave (
      output issuable, stnum_free, fu_valid, fu_op, fu_a, fu_b, fu_tag,
      input  issue_en, issue_type, issue_stnum, issue_op, issue_vj, issue_qj,
             issue_vk, issue_qk, issue_use_imm, issue_immd, issue_imm_zext,
             cdb_valid, cdb_tag, cdb_data, fu_ready
   );

endinterface

// File: rtl/rs_issue_bank_entry.sv
// rs_entry: one reservation-station entry -- state FSM, operand capture at
// issue (with same-cycle CDB bypass) and CDB snooping while waiting.
module rs_entry
   import rs_issue_bank_pkg::*;
#(
   parameter logic [TAG_W-1:0] OWN_TAG = 5'd1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_accept,
   input  logic [OP_W-1:0]   issue_op,
   input  logic [DATA_W-1:0] issue_vj,
   input  logic [TAG_W-1:0]  issue_qj,
   input  logic [DATA_W-1:0] issue_vk,
   input  logic [TAG_W-1:0]  issue_qk,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic              dispatch,
   output logic              is_free,
   output logic              is_ready,
   output logic [OP_W-1:0]   op,
   output logic [DATA_W-1:0] vj,
   output logic [DATA_W-1:0] vk
);

   ent_state_t        state_reg, state_next;
   logic [OP_W-1:0]   op_reg, op_next;
   logic [DATA_W-1:0] vj_reg, vj_next, vk_reg, vk_next;
   logic [TAG_W-1:0]  qj_reg, qj_next, qk_reg, qk_next;
   logic              snoop;

   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      vj_next    = vj_reg;
      qj_next    = qj_reg;
      vk_next    = vk_reg;
      qk_next    = qk_reg;
      snoop      = 1'b0;
      case (state_reg)
         ENT_FREE: begin
            if (issue_accept) begin
               op_next = issue_op;
               vj_next = issue_vj;
               qj_next = issue_qj;
               vk_next = issue_vk;
               qk_next = issue_qk;
               snoop   = 1'b1;
            end
         end
         ENT_WAIT:  snoop = 1'b1;
         ENT_READY: if (dispatch) state_next = ENT_EXEC;
         ENT_EXEC:  if (cdb_valid && cdb_tag == OWN_TAG) state_next = ENT_FREE;
         default:   state_next = ENT_FREE;
      endcase
      // Snooping the freshly issued operands gives the issue/CDB bypass for free.
      if (snoop) begin
         if (cdb_valid && qj_next != TAG_NONE && qj_next == cdb_tag) begin
            vj_next = cdb_data;
            qj_next = TAG_NONE;
         end
         if (cdb_valid && qk_next != TAG_NONE && qk_next == cdb_tag) begin
            vk_next = cdb_data;
            qk_next = TAG_NONE;
         end
         state_next = (qj_next == TAG_NONE && qk_next == TAG_NONE) ? ENT_READY : ENT_WAIT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ENT_FREE;
         op_reg    <= '0;
         vj_reg    <= '0;
         qj_reg    <= TAG_NONE;
         vk_reg    <= '0;
         qk_reg    <= TAG_NONE;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         vj_reg    <= vj_next;
         qj_reg    <= qj_next;
         vk_reg    <= vk_next;
         qk_reg    <= qk_next;
      end
   end

   assign is_free  = (state_reg == ENT_FREE);
   assign is_ready = (state_reg == ENT_READY);
   assign op       = op_reg;
   assign vj       = vj_reg;
   assign vk       = vk_reg;

endmodule

// File: rtl/rs_issue_bank.sv
// Reservation-station bank: allocation, dispatch selection and FU output registers.
// Optional RS_AGE_PRIO_EN: oldest-READY-first dispatch using per-entry age counters.
module rs_issue_bank
   import rs_issue_bank_pkg::*;
#(
   parameter int                NUM_ENT  = 3,
   parameter int                TAG_BASE = 1,
   parameter logic [TYPE_W-1:0] ST_TYPE  = ST_ADD
) (
   input logic           clk,
   input logic           rst,
   rs_issue_bank_if.slave bus
);

   logic [NUM_ENT-1:0] free_vec, ready_vec, accept_vec, dispatch_vec;
   logic [OP_W-1:0]    ent_op [NUM_ENT];
   logic [DATA_W-1:0]  ent_vj [NUM_ENT];
   logic [DATA_W-1:0]  ent_vk [NUM_ENT];
   logic [DATA_W-1:0]  vk_in;
   logic [TAG_W-1:0]   qk_in;
   logic               type_ok;

   logic               sel_found, sel_take;
   logic [OP_W-1:0]    sel_op;
   logic [DATA_W-1:0]  sel_a, sel_b;
   logic [TAG_W-1:0]   sel_tag;

   logic               fu_valid_reg;
   logic [OP_W-1:0]    fu_op_reg;
   logic [DATA_W-1:0]  fu_a_reg, fu_b_reg;
   logic [TAG_W-1:0]   fu_tag_reg;

   assign type_ok = bus.issue_en && (bus.issue_type == ST_TYPE);
   assign vk_in   = bus.issue_use_imm ? ext_imm(bus.issue_immd, bus.issue_imm_zext) : bus.issue_vk;
   assign qk_in   = bus.issue_use_imm ? TAG_NONE : bus.issue_qk;

   generate
      for (genvar gi = 0; gi < NUM_ENT; gi++) begin : g_ent
         localparam logic [TAG_W-1:0] ENT_TAG = TAG_W'(TAG_BASE + gi);

         // Only a slot that was FREE before the edge may accept, so a same-cycle free+issue is ignored.
         assign accept_vec[gi] = type_ok && (bus.issue_stnum == ENT_TAG) && free_vec[gi];

         rs_entry #(.OWN_TAG(ENT_TAG)) u_entry (
            .clk          (clk),
            .rst          (rst),
            .issue_accept (accept_vec[gi]),
            .issue_op     (bus.issue_op),
            .issue_vj     (bus.issue_vj),
            .issue_qj     (bus.issue_qj),
            .issue_vk     (vk_in),
            .issue_qk     (qk_in),
            .cdb_valid    (bus.cdb_valid),
            .cdb_tag      (bus.cdb_tag),
            .cdb_data     (bus.cdb_data),
            .dispatch     (dispatch_vec[gi]),
            .is_free      (free_vec[gi]),
            .is_ready     (ready_vec[gi]),
            .op           (ent_op[gi]),
            .vj           (ent_vj[gi]),
            .vk           (ent_vk[gi])
         );
      end
   endgenerate

`ifdef RS_AGE_PRIO_EN
   logic [AGE_W-1:0] age_reg [NUM_ENT];
   logic [AGE_W-1:0] best_age;

   generate
      for (genvar gi = 0; gi < NUM_ENT; gi++) begin : g_age
         always_ff @(posedge clk) begin
            if (rst) begin
               age_reg[gi] <= '0;
            end else if (accept_vec[gi]) begin
               age_reg[gi] <= '0;
            end else if (|accept_vec && age_reg[gi] != {AGE_W{1'b1}}) begin
               age_reg[gi] <= age_reg[gi] + 1'b1;
            end
         end
      end
   endgenerate
`endif

   always_comb begin
      sel_found    = 1'b0;
      sel_take     = 1'b0;
      sel_op       = '0;
      sel_a        = '0;
      sel_b        = '0;
      sel_tag      = TAG_NONE;
      dispatch_vec = '0;
`ifdef RS_AGE_PRIO_EN
      best_age     = '0;
`endif
      for (int i = 0; i < NUM_ENT; i++) begin
`ifdef RS_AGE_PRIO_EN
         // Strict compare keeps the lowest index on equal ages.
         sel_take = ready_vec[i] && (!sel_found || age_reg[i] > best_age);
         if (sel_take) best_age = age_reg[i];
`else
         sel_take = ready_vec[i] && !sel_found;
`endif
         if (sel_take) begin
            sel_found       = 1'b1;
            sel_op          = ent_op[i];
            sel_a           = ent_vj[i];
            sel_b           = ent_vk[i];
            sel_tag         = TAG_W'(TAG_BASE + i);
            dispatch_vec    = '0;
            dispatch_vec[i] = bus.fu_ready;
         end
      end
   end

   always_comb begin
      bus.stnum_free = TAG_NONE;
      for (int i = NUM_ENT - 1; i >= 0; i--) begin
         if (free_vec[i]) bus.stnum_free = TAG_W'(TAG_BASE + i);
      end
   end
   assign bus.issuable = |free_vec;

   always_ff @(posedge clk) begin
      if (rst) begin
         fu_valid_reg <= 1'b0;
         fu_op_reg    <= '0;
         fu_a_reg     <= '0;
         fu_b_reg     <= '0;
         fu_tag_reg   <= TAG_NONE;
      end else begin
         fu_valid_reg <= 1'b0;
         if (bus.fu_ready && sel_found) begin
            fu_valid_reg <= 1'b1;
            fu_op_reg    <= sel_op;
            fu_a_reg     <= sel_a;
            fu_b_reg     <= sel_b;
            fu_tag_reg   <= sel_tag;
         end
      end
   end

   assign bus.fu_valid = fu_valid_reg;
   assign bus.fu_op    = fu_op_reg;
   assign bus.fu_a     = fu_a_reg;
   assign bus.fu_b     = fu_b_reg;
   assign bus.fu_tag   = fu_tag_reg;

endmodule
